serial_sub: RTL and testbench

//  Bit-serial W-bit subtractor computing d = a - b - bin, LSB first, one bit per clock.

---
 rtl/serial_sub.sv | 103 ++++++++++
 tb/tb_serial_sub.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// Bit-serial W-bit subtractor d = a - b - bin, one LSB-first bit per clock.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_sub #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] d,
    output logic         bo
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        r_state;
    logic [W-1:0]  r_a_sr;
    logic [W-1:0]  r_b_sr;
    logic [W-1:0]  r_res;
    logic          r_br;
    logic [CW-1:0] r_cnt;

    logic w_x;
    logic w_y;
    logic w_diff;
    logic w_borrow;
    logic w_last;

    assign w_x      = r_a_sr[0];
    assign w_y      = r_b_sr[0];
    assign w_diff   = w_x ^ w_y ^ r_br;
    assign w_borrow = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
    assign w_last   = (r_cnt == CW'(W - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_res   <= '0;
            r_br    <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            d       <= '0;
            bo      <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            ovf     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_br    <= bin;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= SHIFT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                SHIFT: begin
                    r_a_sr <= {1'b0, r_a_sr[W-1:1]};
                    r_b_sr <= {1'b0, r_b_sr[W-1:1]};
                    r_res  <= {w_diff, r_res[W-1:1]};
                    r_br   <= w_borrow;
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_last) begin
                        // On the last step the shift-register LSBs are the operand MSBs,
                        // so overflow needs no separately captured sign bits.
                        d       <= {w_diff, r_res[W-1:1]};
                        bo      <= w_borrow;
`ifdef SERIAL_SUB_OVF_EN
                        ovf     <= (w_x ^ w_y) & (w_diff ^ w_x);
`endif
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub.sv
// Self-checking bench for serial_sub: directed vectors, reset abort, back-to-back
// and randomized operations against an arithmetic reference model.
module tb_serial_sub;
    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         bin   = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bo;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] prev_d  = '0;
    logic         prev_bo = 1'b0;

    logic [W-1:0] ca [0:4];
    logic [W-1:0] cb [0:4];
    logic         cbin [0:4];

    serial_sub #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bo    (bo)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // {ovf, bo, d} from plain integer arithmetic
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mbin);
        int ud;
        int sd;
        logic o;
        logic u;
        ud = int'(ma) - int'(mb) - int'(mbin);
        sd = int'($signed(ma)) - int'($signed(mb)) - int'(mbin);
        o  = (sd < -(2 ** (W - 1))) || (sd > (2 ** (W - 1)) - 1);
        u  = (ud < 0);
        return {o, u, W'(ud)};
    endfunction

    task automatic drive(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin);
        start = 1'b1;
        a     = ta;
        b     = tb_v;
        bin   = tbin;
    endtask

    task automatic finish_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin,
                             input bit junk, input bit hold);
        logic [W+1:0] e;
        e = model(ta, tb_v, tbin);
        @(negedge clk);
        for (int i = 0; i < W; i++) begin
            chk("busy_shift", busy, 1'b1);
            chk("done_shift", done, 1'b0);
            chk("d_hold", d, prev_d);
            chk("bo_hold", bo, prev_bo);
            start = hold ? 1'b1 : (junk ? 1'($urandom_range(0, 1)) : 1'b0);
            a     = W'($urandom);
            b     = W'($urandom);
            bin   = 1'($urandom);
            @(negedge clk);
        end
        chk("done", done, 1'b1);
        chk("busy_done", busy, 1'b0);
        chk("d", d, e[W-1:0]);
        chk("bo", bo, e[W]);
`ifdef SERIAL_SUB_OVF_EN
        chk("ovf", ovf, e[W+1]);
`endif
        prev_d  = e[W-1:0];
        prev_bo = e[W];
        if (!hold) begin
            start = 1'b0;
            @(negedge clk);
            chk("done_single", done, 1'b0);
            chk("d_after", d, prev_d);
            chk("busy_idle", busy, 1'b0);
        end
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_d", d, 8'h00);
        chk("rst_bo", bo, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
        chk("rst_ovf", ovf, 1'b0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // directed vectors
        drive(8'd100, 8'd37, 1'b0); finish_op(8'd100, 8'd37, 1'b0, 0, 0);
        drive(8'd0, 8'd1, 1'b0);    finish_op(8'd0, 8'd1, 1'b0, 0, 0);
        drive(8'd5, 8'd5, 1'b1);    finish_op(8'd5, 8'd5, 1'b1, 0, 0);
        drive(8'h80, 8'h01, 1'b0);  finish_op(8'h80, 8'h01, 1'b0, 0, 0);
        drive(8'h10, 8'h01, 1'b0);  finish_op(8'h10, 8'h01, 1'b0, 0, 0);
        drive(8'h7F, 8'hFF, 1'b1);  finish_op(8'h7F, 8'hFF, 1'b1, 0, 0);
        drive(8'hFF, 8'h7F, 1'b1);  finish_op(8'hFF, 8'hFF - 8'h80, 1'b1, 0, 0);

        // start pulses during SHIFT are ignored
        drive(8'hC3, 8'h5A, 1'b1);  finish_op(8'hC3, 8'h5A, 1'b1, 1, 0);

        // reset in the middle of a shift aborts with no done pulse
        drive(8'h3C, 8'h15, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_d", d, 8'h00);
        chk("abort_bo", bo, 1'b0);
        rst_n   = 1'b1;
        prev_d  = '0;
        prev_bo = 1'b0;
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            chk("abort_no_done", done, 1'b0);
        end
        drive(8'h3C, 8'h15, 1'b0);  finish_op(8'h3C, 8'h15, 1'b0, 0, 0);

        // start held high: back-to-back operations
        for (int k = 0; k < 5; k++) begin
            ca[k]   = W'($urandom);
            cb[k]   = W'($urandom);
            cbin[k] = 1'($urandom);
        end
        for (int k = 0; k < 5; k++) begin
            drive(ca[k], cb[k], cbin[k]);
            finish_op(ca[k], cb[k], cbin[k], 1, (k != 4));
        end

        // randomized operations
        for (int k = 0; k < 24; k++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rbin;
            ra   = W'($urandom);
            rb   = (k % 6 == 0) ? ra : W'($urandom);
            rbin = 1'($urandom);
            drive(ra, rb, rbin);
            finish_op(ra, rb, rbin, bit'($urandom_range(0, 1)), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
